// File: rtl/spi_gyro_responder.sv
`timescale 1ns/1ps
// spi_gyro_responder: mode-3 SPI slave emulating the L3G4200D register map of the PmodGYRO
module spi_gyro_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST = 8'h0F
) (
  input  logic        GCLK,
  input  logic        RST,
  input  logic        CS_N,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  input  logic [7:0]  temp_data,
  input  logic        data_valid,
  output logic [7:0]  ctrl1,
  output logic [7:0]  ctrl2,
  output logic [7:0]  ctrl3,
  output logic [7:0]  ctrl4,
  output logic [7:0]  ctrl5,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_n;
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, wr_en, clr;
  logic [2:0] bit_cnt;
  logic [7:0] rx, rx_next, tx, rd_data;
  logic rw, ms;
  logic [5:0] addr, addr_n;
  logic [7:0] ctrl [5];
  logic [15:0] x_s, y_s, z_s;
  logic [7:0] t_s;
  logic zyxda, zyxor;
  // cs sync resets low so a CS_N already held low after reset never looks like a fall
  assign cs_fall = cs_q[2] & ~cs_q[1];
  assign cs_rise = ~cs_q[2] & cs_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign rx_next = {rx[6:0], mosi_q[1]};
  assign byte_done = state != IDLE && !cs_rise && sclk_rise && bit_cnt == 3'd7;
  assign wr_en = byte_done && state == DATA && !rw && addr >= 6'h20 && addr <= 6'h24;
  assign clr = byte_done && state == DATA && rw && addr == 6'h2D;
  assign addr_n = state == CMD ? rx_next[5:0] : ms ? addr + 6'd1 : addr;
  assign {ctrl1, ctrl2, ctrl3, ctrl4, ctrl5} = {ctrl[0], ctrl[1], ctrl[2], ctrl[3], ctrl[4]};
  always_comb begin
    rd_data = 8'h00;
    case (addr_n)
      6'h0F: rd_data = WHO_AM_I_VAL;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24: rd_data = ctrl[addr_n[2:0]];
      6'h26: rd_data = t_s;
      6'h27: rd_data = {zyxor, 3'b000, zyxda, 3'b000};
      6'h28: rd_data = x_s[7:0];
      6'h29: rd_data = x_s[15:8];
      6'h2A: rd_data = y_s[7:0];
      6'h2B: rd_data = y_s[15:8];
      6'h2C: rd_data = z_s[7:0];
      6'h2D: rd_data = z_s[15:8];
      default: rd_data = 8'h00;
    endcase
  end
  always_comb
    state_n = cs_rise ? IDLE :
              (state == IDLE && cs_fall) ? CMD :
              (state == CMD && byte_done) ? DATA : state;
  always_ff @(posedge GCLK)
    state <= RST ? IDLE : state_n;
  always_ff @(posedge GCLK) begin
    if (RST) begin
      cs_q <= '0;
      sclk_q <= '1;
      mosi_q <= '0;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
      rw <= 1'b0;
      ms <= 1'b0;
      addr <= '0;
      MISO <= 1'b0;
      MISO_OE <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      zyxda <= 1'b0;
      zyxor <= 1'b0;
      ctrl[0] <= CTRL1_RST;
      ctrl[1] <= '0;
      ctrl[2] <= '0;
      ctrl[3] <= '0;
      ctrl[4] <= '0;
      x_s <= '0;
      y_s <= '0;
      z_s <= '0;
      t_s <= '0;
    end else begin
      cs_q <= {cs_q[1:0], CS_N};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
      wr_strobe <= wr_en;
      if (wr_en) begin
        ctrl[addr[2:0]] <= rx_next;
        wr_addr <= addr;
      end
      zyxda <= data_valid | (zyxda & ~clr);
      zyxor <= (data_valid & zyxda) | (zyxor & ~clr);
      if (cs_fall) {x_s, y_s, z_s, t_s} <= {x_data, y_data, z_data, temp_data};
      if (cs_rise) MISO_OE <= 1'b0;
      else if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        MISO_OE <= 1'b1;
        MISO <= 1'b0;
      end else if (state != IDLE) begin
        if (state == DATA && sclk_fall) begin
          MISO <= tx[7];
          tx <= {tx[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (state == CMD) {rw, ms} <= rx_next[7:6];
            addr <= addr_n;
            tx <= (wr_en && !ms) ? rx_next : rd_data;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_gyro_responder.sv
`timescale 1ns/1ps
// tb_spi_gyro_responder: directed SPI master with MISO-byte and write-strobe scoreboards
module tb_spi_gyro_responder;
  logic GCLK = 0, RST = 1, CS_N = 1, SCLK = 1, MOSI = 0, data_valid = 0;
  logic [15:0] x_data = 0, y_data = 0, z_data = 0;
  logic [7:0] temp_data = 0;
  logic MISO, MISO_OE, wr_strobe;
  logic [7:0] ctrl1, ctrl2, ctrl3, ctrl4, ctrl5;
  logic [5:0] wr_addr;
  typedef struct packed {logic [5:0] a; logic [7:0] d;} wr_t;
  logic [7:0] miso_q[$];
  wr_t wr_q[$];
  wr_t we;
  int n_cmp = 0, n_bad = 0, nb = 0;
  logic [7:0] sh = 0;

  spi_gyro_responder dut (
    .GCLK(GCLK), .RST(RST), .CS_N(CS_N), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .x_data(x_data), .y_data(y_data), .z_data(z_data), .temp_data(temp_data), .data_valid(data_valid),
    .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3), .ctrl4(ctrl4), .ctrl5(ctrl5),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 GCLK = ~GCLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_at(input logic [5:0] a);
    case (a)
      6'h20: return ctrl1;
      6'h21: return ctrl2;
      6'h22: return ctrl3;
      6'h23: return ctrl4;
      6'h24: return ctrl5;
      default: return 8'h00;
    endcase
  endfunction

  // master samples MISO on SCLK rise; partial bytes are dropped on CS_N rise or reset
  always @(posedge SCLK or posedge CS_N or posedge RST) begin
    if (CS_N || RST) nb = 0;
    else begin
      sh = {sh[6:0], MISO};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (miso_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL miso_unexpected: got %h expected none", sh);
        end else check("miso_byte", {8'h00, sh}, {8'h00, miso_q.pop_front()});
      end
    end
  end

  always @(negedge GCLK)
    if (wr_strobe) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr %h expected no strobe", wr_addr);
      end else begin
        we = wr_q.pop_front();
        check("wr_addr", {10'h0, wr_addr}, {10'h0, we.a});
        check("wr_data", {8'h0, ctrl_at(we.a)}, {8'h0, we.d});
      end
    end

  task automatic clk_n(input int n);
    repeat (n) @(negedge GCLK);
  endtask

  task automatic bit_x(input logic b, input logic dv);
    SCLK = 0;
    MOSI = b;
    clk_n(8);
    SCLK = 1;
    if (dv) begin
      // lands data_valid on the cycle the synced 8th rise completes the byte
      repeat (2) @(posedge GCLK);
      @(negedge GCLK) data_valid = 1;
      @(negedge GCLK) data_valid = 0;
      clk_n(5);
    end else clk_n(8);
  endtask

  task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input logic dv = 0);
    miso_q.push_back(exp);
    for (int i = 7; i >= 0; i--) bit_x(b[i], dv && i == 0);
  endtask

  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) bit_x(b[7-i], 1'b0);
  endtask

  task automatic cs_low;
    clk_n(1);
    CS_N = 0;
    clk_n(8);
  endtask

  task automatic cs_high;
    clk_n(8);
    CS_N = 1;
    clk_n(12);
  endtask

  task automatic dv_pulse;
    @(negedge GCLK) data_valid = 1;
    @(negedge GCLK) data_valid = 0;
    clk_n(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_n(4);
    RST = 0;
    clk_n(4);
    check("rst_miso_oe", {15'h0, MISO_OE}, 16'h0);
    check("rst_miso", {15'h0, MISO}, 16'h0);
    check("rst_ctrl1", {8'h0, ctrl1}, 16'h000F);
    check("rst_ctrl2", {8'h0, ctrl2}, 16'h0);
    check("rst_wr_strobe", {15'h0, wr_strobe}, 16'h0);
    check("rst_wr_addr", {10'h0, wr_addr}, 16'h0);
    // WHO_AM_I
    cs_low;
    xfer(8'h8F, 8'h00);
    check("oe_during_cs", {15'h0, MISO_OE}, 16'h1);
    xfer(8'h00, 8'hD3);
    cs_high;
    check("oe_after_cs", {15'h0, MISO_OE}, 16'h0);
    // write ctrl1 then read back
    cs_low;
    xfer(8'h20, 8'h00);
    wr_q.push_back('{a: 6'h20, d: 8'hAB});
    xfer(8'hAB, 8'h0F);
    cs_high;
    check("ctrl1_written", {8'h0, ctrl1}, 16'h00AB);
    check("wr_addr_hold", {10'h0, wr_addr}, 16'h0020);
    cs_low;
    xfer(8'hA0, 8'h00);
    xfer(8'h00, 8'hAB);
    cs_high;
    // STATUS after two unread samples
    dv_pulse;
    dv_pulse;
    cs_low;
    xfer(8'hA7, 8'h00);
    xfer(8'h00, 8'h88);
    cs_high;
    // coherent burst, x changes mid-burst
    x_data = 16'h1234;
    y_data = 16'hFEDC;
    z_data = 16'h8001;
    cs_low;
    xfer(8'hE8, 8'h00);
    xfer(8'h00, 8'h34);
    x_data = 16'hFFFF;
    xfer(8'h00, 8'h12);
    xfer(8'h00, 8'hDC);
    xfer(8'h00, 8'hFE);
    xfer(8'h00, 8'h01);
    xfer(8'h00, 8'h80);
    cs_high;
    cs_low;
    xfer(8'hA7, 8'h00);
    xfer(8'h00, 8'h00);
    cs_high;
    // data_valid coincides with the 0x2D byte completing
    x_data = 16'hA55A;
    cs_low;
    xfer(8'hE8, 8'h00);
    xfer(8'h00, 8'h5A);
    xfer(8'h00, 8'hA5);
    xfer(8'h00, 8'hDC);
    xfer(8'h00, 8'hFE);
    xfer(8'h00, 8'h01);
    xfer(8'h00, 8'h80, 1'b1);
    cs_high;
    cs_low;
    xfer(8'hA7, 8'h00);
    xfer(8'h00, 8'h08);
    cs_high;
    // auto-increment wrap 0x3F -> 0x00
    cs_low;
    xfer(8'hFF, 8'h00);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'h00);
    cs_high;
    // non-incrementing writes: next byte returns the value just written
    cs_low;
    xfer(8'h24, 8'h00);
    wr_q.push_back('{a: 6'h24, d: 8'h5A});
    xfer(8'h5A, 8'h00);
    wr_q.push_back('{a: 6'h24, d: 8'h3C});
    xfer(8'h3C, 8'h5A);
    cs_high;
    check("ctrl5_written", {8'h0, ctrl5}, 16'h003C);
    // partial write aborted by CS_N
    cs_low;
    xfer(8'h21, 8'h00);
    bits(8'hFF, 5);
    cs_high;
    check("ctrl2_abort", {8'h0, ctrl2}, 16'h0);
    // reset mid-burst with CS_N held low
    cs_low;
    xfer(8'hE8, 8'h00);
    bits(8'hFF, 3);
    RST = 1;
    clk_n(3);
    RST = 0;
    clk_n(6);
    check("rst_mid_ctrl1", {8'h0, ctrl1}, 16'h000F);
    check("rst_mid_oe", {15'h0, MISO_OE}, 16'h0);
    xfer(8'h20, 8'h00);
    xfer(8'h55, 8'h00);
    check("rst_ignore_ctrl1", {8'h0, ctrl1}, 16'h000F);
    check("rst_ignore_oe", {15'h0, MISO_OE}, 16'h0);
    cs_high;
    cs_low;
    xfer(8'h8F, 8'h00);
    xfer(8'h00, 8'hD3);
    cs_high;
    // write to read-only WHO_AM_I is dropped
    cs_low;
    xfer(8'h0F, 8'h00);
    xfer(8'h55, 8'hD3);
    cs_high;
    cs_low;
    xfer(8'h8F, 8'h00);
    xfer(8'h00, 8'hD3);
    cs_high;
    clk_n(10);
    check("miso_q_drained", 16'(miso_q.size()), 16'h0);
    check("wr_q_drained", 16'(wr_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
SPI slave that emulates the L3G4200D register interface of the PmodGYRO. It answers the same mode-3 transactions the PmodGYRO master issues. Internal sample words are presented on its ports, so the gyro reader and OLED/D2STR display path can run in simulation and in loopback on JA without the physical sensor. All SPI lines are oversampled on GCLK.

Parameters:
WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F
CTRL1_RST, 8'h0F, reset value of CTRL_REG1 (0x20)

Ports:
GCLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous active-high reset
CS_N  in  1  SPI chip select, active low, asynchronous to GCLK
SCLK  in  1  SPI clock, CPOL=1/CPHA=1, asynchronous to GCLK
MOSI  in  1  SPI data from master
MISO  out  1  SPI data to master
MISO_OE  out  1  1 = drive MISO; 0 = tristate request to the pad
x_data, y_data, z_data  in  16 each  two's-complement axis samples
temp_data  in  8  temperature sample
data_valid  in  1  one-cycle pulse: new sample set present on the data ports
ctrl1..ctrl5  out  8 each  current CTRL_REG1..5 (0x20..0x24)
wr_strobe  out  1  one-cycle pulse after any accepted register write
wr_addr  out  6  address of the last accepted write

Behaviour:
- Reset values: MISO=0, MISO_OE=0, ctrl1=CTRL1_RST, ctrl2..5=0, wr_strobe=0, wr_addr=0, STATUS=0, state IDLE.
- CS_N, SCLK and MOSI each pass through a 2-FF synchronizer, then a registered edge detector.
  - Detection latency is 3 GCLK cycles.
  - SCLK high and low phases must each be at least 4 GCLK cycles.
- Register map:
  - 0x0F WHO_AM_I (RO).
  - 0x20..0x24 CTRL1..5 (RW).
  - 0x26 OUT_TEMP (RO).
  - 0x27 STATUS (RO): bit7 ZYXOR, bit3 ZYXDA, others 0.
  - 0x28..0x2D OUT_X_L, X_H, Y_L, Y_H, Z_L, Z_H (RO).
  - Every other address reads 0x00; writes to it are ignored.
- Snapshot: on each synced CS_N falling edge, x/y/z/temp_data are copied into shadow registers. All OUT_* reads in that transaction return the shadow copy, so a burst is coherent.
- States: IDLE, CMD, DATA.
  - IDLE -> CMD on CS_N fall. Bit counter = 0, MISO_OE=1, MISO=0.
  - CMD: MOSI is sampled on each SCLK rise, MSB first. After the 8th rise, latch rw=bit7, ms=bit6, addr=bits5:0; load tx_shift with reg[addr]; go to DATA.
  - DATA: on each SCLK fall, MISO <= tx_shift[7] and tx_shift shifts left. On each rise, MOSI shifts into rx. After the 8th rise of a byte:
    - If rw=0 and addr is RW: write rx to the register; wr_strobe=1 for one cycle; wr_addr=addr. RO or unmapped writes are dropped with no strobe.
    - If ms=1: addr <= addr+1, wrapping 0x3F->0x00. Otherwise addr is unchanged.
    - Load tx_shift with reg[new addr] from the live register value. This value reflects a write that completed on the same byte.
  - Any state -> IDLE on CS_N rise. A partial byte is discarded (no write, no strobe) and MISO_OE=0.
- STATUS:
  - data_valid sets ZYXDA. If ZYXDA is already 1 when data_valid arrives, ZYXOR is also set.
  - Both bits clear when a read byte at address 0x2D completes.
  - If set and clear fall in the same cycle, set wins.
- Writes land on the GCLK cycle after the synced 8th SCLK rise of the byte.
- RST asserted mid-transaction: the transaction is abandoned and registers return to reset values. After RST deasserts, the block stays in IDLE until a fresh CS_N falling edge; a CS_N already low at that point is ignored until it rises and falls again.
- SCLK edges while CS_N is high are ignored.

Test Plan:
- Read WHO_AM_I: master sends 0x8F, then 8 clocks -> MISO byte 0xD3; MISO_OE high only while CS_N is low.
- Write then read back: 0x20,0xAB -> wr_strobe pulses once with wr_addr=0x20 and ctrl1=0xAB; next transaction 0xA0 -> 0xAB.
- Burst read: x=0x1234, y=0xFEDC, z=0x8001, then 0xE8 plus 6 bytes -> 34 12 DC FE 01 80. Changing x_data mid-burst does not alter the bytes.
- Auto-increment wrap: 0xFF plus 2 bytes -> reg 0x3F then reg 0x00, i.e. 0x00, 0x00.
- STATUS: two data_valid pulses with no read -> 0xA7 reads 0x88. Burst 0xE8 through 0x2D -> next STATUS read 0x00. data_valid in the same cycle as the 0x2D read completing -> ZYXDA stays 1.
- Aborts:
  - CS_N rises after 5 data bits of a write to 0x21 -> ctrl2 unchanged, no wr_strobe.
  - RST during a burst with CS_N held low -> ctrl1=0x0F, MISO_OE=0, no response until CS_N toggles.
  - Write to 0x0F -> dropped, no wr_strobe.
